// File: rtl/tmip_pkg.sv
// Shared types and helpers for the TMIP grayscale capture front-end.
package tmip_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_4  = 2'd0;
    localparam logic [1:0] SZ_8  = 2'd1;
    localparam logic [1:0] SZ_16 = 2'd2;
    localparam logic [1:0] SZ_32 = 2'd3;

    // Image side in pixels for a size code, clamped to the configured maximum.
    function automatic int unsigned dim_from_code(input logic [1:0] code,
                                                  input int unsigned max_dim);
        int unsigned d;
        d = 32'd4 << code;
        if (d > max_dim) begin
            d = max_dim;
        end
        return d;
    endfunction

endpackage

// File: rtl/tmip_chan_reduce.sv
// Per-pixel channel reduction: running max, sum and weighted gray over CH beats.
// Result registered on the last channel beat; held between pixels.
module tmip_chan_reduce #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_vld,
    input  logic             first,
    input  logic             last,
    input  logic [CW-1:0]    ch_idx,
    input  logic [PIX_W-1:0] sample,
    output logic             res_vld,
    output logic [PIX_W-1:0] res_max,
    output logic [PIX_W-1:0] res_avg,
    output logic [PIX_W-1:0] res_wgt
);

    localparam int SUM_W = PIX_W + $clog2(CH);

    logic [PIX_W-1:0] max_q, max_d, base_max, cur_max;
    logic [SUM_W-1:0] sum_q, sum_d, cur_sum;
    logic [PIX_W-1:0] wacc_q, wacc_d, term, cur_wacc, avg_v;
    logic             res_vld_q, res_vld_d;
    logic [PIX_W-1:0] res_max_q, res_max_d, res_avg_q, res_avg_d, res_wgt_q, res_wgt_d;

    always_comb begin
        // first beat restarts the accumulators, which also drops any partial pixel
        base_max = first ? '0 : max_q;
        cur_max  = (sample > base_max) ? sample : base_max;
        cur_sum  = (first ? '0 : sum_q) + SUM_W'(sample);
        term     = (ch_idx == CW'(1)) ? (sample >> 1) : (sample >> 2);
        cur_wacc = (first ? '0 : wacc_q) + term;
        avg_v    = PIX_W'(cur_sum / SUM_W'(CH));

        max_d     = max_q;
        sum_d     = sum_q;
        wacc_d    = wacc_q;
        res_vld_d = 1'b0;
        res_max_d = res_max_q;
        res_avg_d = res_avg_q;
        res_wgt_d = res_wgt_q;
        if (beat_vld) begin
            max_d  = cur_max;
            sum_d  = cur_sum;
            wacc_d = cur_wacc;
            if (last) begin
                res_vld_d = 1'b1;
                res_max_d = cur_max;
                res_avg_d = avg_v;
                res_wgt_d = (CH == 3) ? cur_wacc : avg_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q     <= '0;
            sum_q     <= '0;
            wacc_q    <= '0;
            res_vld_q <= 1'b0;
            res_max_q <= '0;
            res_avg_q <= '0;
            res_wgt_q <= '0;
        end else begin
            max_q     <= max_d;
            sum_q     <= sum_d;
            wacc_q    <= wacc_d;
            res_vld_q <= res_vld_d;
            res_max_q <= res_max_d;
            res_avg_q <= res_avg_d;
            res_wgt_q <= res_wgt_d;
        end
    end

    assign res_vld = res_vld_q;
    assign res_max = res_max_q;
    assign res_avg = res_avg_q;
    assign res_wgt = res_wgt_q;

endmodule

// File: rtl/tmip_gray_capture.sv
// Capture front-end: channel-interleaved stream -> one max/avg/weighted write per pixel.
// Write appears the cycle after the last channel beat; no backpressure, in_valid frames the image.
module tmip_gray_capture
    import tmip_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int CH      = 3,
    parameter int MAX_DIM = 16,
    parameter int ADDR_W  = $clog2(MAX_DIM * MAX_DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  image,
    input  logic [1:0]        image_size,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_max,
    output logic [PIX_W-1:0]  wr_avg,
    output logic [PIX_W-1:0]  wr_wgt,
    output logic              frame_done,
    output logic              abort,
    output logic              overflow,
    output logic              busy
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     ch_cnt_q, ch_cnt_d, cur_ch;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d, cur_pix;
    logic [ADDR_W-1:0] last_pix_q, last_pix_d, cur_last_pix;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              overflow_q, overflow_d, abort_q, abort_d;
    logic              busy_q, busy_d, frame_done_q, frame_done_d;
    logic              accept, ch_first, ch_last, pix_last;
    int unsigned       dim;

    // In IDLE the incoming beat is channel 0 of pixel 0 with a freshly decoded size.
    always_comb begin
        dim          = dim_from_code(image_size, MAX_DIM);
        accept       = in_valid && (state_q != DRAIN);
        cur_ch       = (state_q == IDLE) ? '0 : ch_cnt_q;
        cur_pix      = (state_q == IDLE) ? '0 : pix_cnt_q;
        cur_last_pix = (state_q == IDLE) ? ADDR_W'(dim * dim - 1) : last_pix_q;
        ch_first     = (cur_ch == '0);
        ch_last      = (cur_ch == CW'(CH - 1));
        pix_last     = (cur_pix == cur_last_pix);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (ch_last && pix_last) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (!in_valid) begin
                    state_d = IDLE;
                end else if (ch_last && pix_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_cnt_d     = cur_ch;
        pix_cnt_d    = cur_pix;
        if (accept) begin
            if (ch_last) begin
                ch_cnt_d  = '0;
                pix_cnt_d = cur_pix + 1'b1;
            end else begin
                ch_cnt_d  = cur_ch + 1'b1;
            end
        end
        if (state_d != CAPTURE) begin
            ch_cnt_d  = '0;
            pix_cnt_d = '0;
        end

        last_pix_d = (state_q == IDLE && in_valid) ? cur_last_pix : last_pix_q;

        overflow_d = overflow_q;
        if (state_q == IDLE && in_valid) begin
            overflow_d = 1'b0;
        end else if (state_q == DRAIN && in_valid) begin
            overflow_d = 1'b1;
        end

        abort_d      = (state_q == CAPTURE) && !in_valid;
        busy_d       = (state_d == CAPTURE);
        wr_addr_d    = (accept && ch_last) ? cur_pix : wr_addr_q;
        frame_done_d = accept && ch_last && pix_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q     <= '0;
            pix_cnt_q    <= '0;
            last_pix_q   <= '0;
            wr_addr_q    <= '0;
            overflow_q   <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ch_cnt_q     <= ch_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            last_pix_q   <= last_pix_d;
            wr_addr_q    <= wr_addr_d;
            overflow_q   <= overflow_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    tmip_chan_reduce #(
        .PIX_W (PIX_W),
        .CH    (CH),
        .CW    (CW)
    ) u_reduce (
        .clk      (clk),
        .rst      (rst),
        .beat_vld (accept),
        .first    (ch_first),
        .last     (ch_last),
        .ch_idx   (cur_ch),
        .sample   (image),
        .res_vld  (wr_en),
        .res_max  (wr_max),
        .res_avg  (wr_avg),
        .res_wgt  (wr_wgt)
    );

    assign wr_addr    = wr_addr_q;
    assign frame_done = frame_done_q;
    assign abort      = abort_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: doc/tmip_gray_capture.md
Name: tmip_gray_capture

Overview:
- Parametrised front-end for the TMIP template-matching engine.
- Receives a channel-interleaved colour image stream and reduces each pixel to three grayscale variants in one pass: max, average and weighted.
- Emits one write per pixel, row-major, to the engine's image buffer.
- Successor to the fixed 8-bit, 3-channel capture: pixel width, channel count and maximum image dimension are configurable, and overflow/abort detection is added.

Parameters:
- PIX_W, 8, bits per channel sample
- CH, 3, channels per pixel (beats per pixel), 1..8
- MAX_DIM, 16, largest image side in pixels, power of two, 4..64
- ADDR_W, clog2(MAX_DIM*MAX_DIM), write address width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  stream qualifier; high for the whole frame
- image  in  PIX_W  channel sample, order ch0..ch(CH-1) per pixel
- image_size  in  2  size code, sampled on the first in_valid beat only
- wr_en  out  1  pixel result valid
- wr_addr  out  ADDR_W  pixel index, row-major
- wr_max  out  PIX_W  max over channels
- wr_avg  out  PIX_W  floor(sum/CH)
- wr_wgt  out  PIX_W  weighted gray
- frame_done  out  1  one-cycle pulse on the last pixel write
- abort  out  1  one-cycle pulse when in_valid drops mid-frame
- overflow  out  1  sticky: excess beats received
- busy  out  1  high while in CAPTURE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset: all outputs 0, FSM to IDLE, counters 0. Assertion mid-frame discards the frame immediately.
- Size decode: dim = 4 << image_size. If dim > MAX_DIM, clamp to MAX_DIM. npix = dim*dim.
- FSM states: IDLE, CAPTURE, DRAIN.
  - IDLE -> CAPTURE on in_valid. That beat is channel 0 of pixel 0; clear overflow and latch npix.
  - CAPTURE -> DRAIN when the last channel of pixel npix-1 is accepted.
  - CAPTURE -> IDLE if in_valid is low in any cycle. Pulse abort next cycle; no frame_done; the partial pixel is discarded.
  - DRAIN -> IDLE when in_valid is low. While in DRAIN, each beat with in_valid high sets overflow and is otherwise ignored.
- Channel counter: 0..CH-1, wraps at CH-1. Pixel counter: 0..npix-1.
- Reduction runs per pixel over CH beats:
  - running max, width PIX_W;
  - running sum, width PIX_W+clog2(CH);
  - weighted accumulator.
- Weights:
  - CH==3: wgt = (c0>>2) + (c1>>1) + (c2>>2), each term floored before adding.
  - CH!=3: wgt = avg.
- Average: floor(sum/CH), constant divide; no rounding.
- Latency: last channel beat of a pixel accepted at edge t -> wr_en=1 with final values in cycle t+1, for exactly one cycle. wr_addr = pixel index.
- Outputs wr_addr/wr_max/wr_avg/wr_wgt hold their last values when wr_en=0.
- frame_done is coincident with the wr_en for pixel npix-1.
- busy = (state == CAPTURE), registered.
- Back-to-back frames: a new frame may start in the cycle after in_valid goes low. Addressing restarts at 0.

Decomposition:
- Shared package tmip_pkg holds:
  - state enum {IDLE, CAPTURE, DRAIN};
  - size-code constants SZ_4, SZ_8, SZ_16, SZ_32;
  - function dim_from_code(code, max_dim).
- One sub-module, tmip_chan_reduce: per-pixel max/sum/weighted accumulator with first/last channel strobes, parametrised by PIX_W and CH.

Test Plan:
- Single pixel, defaults: image_size=0, beats 200,100,50 -> wr_en in the cycle after the 50 beat, wr_addr=0, wr_max=200, wr_avg=116, wr_wgt=112.
- Full 4x4 frame (48 beats, all channels 255) -> 16 writes, addr 0..15, each max=255, avg=255, wgt=253; frame_done with addr 15; busy low afterwards.
- Abort: in_valid low after 7 beats -> writes at addr 0 and 1 only, abort pulse, no frame_done. Next frame begins at addr 0.
- Clamp: MAX_DIM=16, image_size=3 -> 256 writes, last wr_addr=255, frame_done once.
- Overflow: 4x4 frame with 50 beats -> 16 writes; overflow rises after beat 49 and clears on the next frame's first beat.
- Reset and generality:
  - rst pulsed at pixel 5 -> all outputs 0 asynchronously; the following frame starts at addr 0.
  - CH=4 variant with samples 10,20,30,41 -> avg=25, wgt=25, max=41.
